// File: rtl/d_reg_pkg.sv
// Shared mode encodings for the register bank, its channels and the bench.
package d_reg_pkg;
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_SHR  = 2'b11;
endpackage

// File: rtl/d_reg_bank_if.sv
// Bus bundle for the register bank: shared controls, per-channel data, handshake and status.
interface d_reg_bank_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
);
   logic                   clr;
   logic [1:0]             mode;
   logic [NCH-1:0]         en;
   logic [NCH*WIDTH-1:0]   d;
   logic [NCH-1:0]         sin;
   logic [NCH*WIDTH-1:0]   q;
   logic [NCH*WIDTH-1:0]   qc;
   logic [NCH-1:0]         sout;
   logic [NCH-1:0]         valid;
   logic [NCH-1:0]         ready;
   logic [NCH-1:0]         ovf;

   modport master (output clr, mode, en, d, sin, ready,
                   input  q, qc, sout, valid, ovf);
   modport slave  (input  clr, mode, en, d, sin, ready,
                   output q, qc, sout, valid, ovf);
endinterface

// File: rtl/d_reg_chan.sv
// One storage channel: data register with load/shift, valid/overflow flags,
// optional load-time bypass and serial-out selection.
module d_reg_chan
   import d_reg_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int TRANSP = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic [1:0]       i_mode,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_sin,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_qc,
   output logic             o_sout,
   output logic             o_valid,
   output logic             o_ovf
);
   logic [WIDTH-1:0] r_q;
   logic             r_valid;
   logic             r_ovf;
   logic             w_load;
   logic [WIDTH-1:0] w_q;

   assign w_load = (i_mode == MODE_LOAD) && i_en;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_q     <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (i_en) begin
            case (i_mode)
               MODE_LOAD: r_q <= i_d;
               MODE_SHL:  r_q <= {r_q[WIDTH-2:0], i_sin};
               MODE_SHR:  r_q <= {i_sin, r_q[WIDTH-1:1]};
               default:   r_q <= r_q;
            endcase
         end
         // A load always re-arms valid, so a same-cycle accept never loses the new word.
         if (w_load)
            r_valid <= 1'b1;
         else if (r_valid && i_ready)
            r_valid <= 1'b0;
         if (w_load && r_valid && !i_ready)
            r_ovf <= 1'b1;
      end
   end

   assign w_q     = ((TRANSP != 0) && w_load && !rst && !i_clr) ? i_d : r_q;
   assign o_q     = w_q;
   assign o_qc    = ~w_q;
   assign o_sout  = (i_mode == MODE_SHL) ? w_q[WIDTH-1] :
                    (i_mode == MODE_SHR) ? w_q[0] : 1'b0;
   assign o_valid = r_valid;
   assign o_ovf   = r_ovf;
endmodule

// File: rtl/d_reg_bank.sv
// NCH independent storage channels sharing mode/clear/reset; the top only slices the bus.
module d_reg_bank
   import d_reg_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NCH    = 4,
   parameter int TRANSP = 0
) (
   input  logic         clk,
   input  logic         rst,
   d_reg_bank_if.slave  bus
);
   for (genvar c = 0; c < NCH; c++) begin : g_chan
      d_reg_chan #(
         .WIDTH  (WIDTH),
         .TRANSP (TRANSP)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .i_clr   (bus.clr),
         .i_mode  (bus.mode),
         .i_en    (bus.en[c]),
         .i_d     (bus.d[c*WIDTH +: WIDTH]),
         .i_sin   (bus.sin[c]),
         .i_ready (bus.ready[c]),
         .o_q     (bus.q[c*WIDTH +: WIDTH]),
         .o_qc    (bus.qc[c*WIDTH +: WIDTH]),
         .o_sout  (bus.sout[c]),
         .o_valid (bus.valid[c]),
         .o_ovf   (bus.ovf[c])
      );
   end
endmodule

// File: tb/tb_d_reg_bank.sv
// Directed bench for d_reg_bank: a registered build and a transparent build driven in parallel.
module tb_d_reg_bank;
   import d_reg_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [1:0]  mode;
   logic [3:0]  en;
   logic [31:0] d;
   logic [3:0]  sin;
   logic [3:0]  ready;
   int          nvec = 0;
   int          nmis = 0;

   always #5 clk = ~clk;

   d_reg_bank_if #(.WIDTH(8), .NCH(4)) bus0 ();
   d_reg_bank_if #(.WIDTH(8), .NCH(4)) bus1 ();

   assign bus0.clr = clr;   assign bus1.clr = clr;
   assign bus0.mode = mode; assign bus1.mode = mode;
   assign bus0.en = en;     assign bus1.en = en;
   assign bus0.d = d;       assign bus1.d = d;
   assign bus0.sin = sin;   assign bus1.sin = sin;
   assign bus0.ready = ready; assign bus1.ready = ready;

   d_reg_bank #(.WIDTH(8), .NCH(4), .TRANSP(0)) dut   (.clk(clk), .rst(rst), .bus(bus0.slave));
   d_reg_bank #(.WIDTH(8), .NCH(4), .TRANSP(1)) dut_t (.clk(clk), .rst(rst), .bus(bus1.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // 1 reset with hostile inputs
      rst = 1'b1; clr = 1'b0; mode = MODE_LOAD; en = 4'hF;
      d = 32'hFFFF_FFFF; sin = 4'h0; ready = 4'h0;
      edge_step();
      edge_step();
      chk("rst_q",     bus0.q, 32'h0000_0000);
      chk("rst_qc",    bus0.qc, 32'hFFFF_FFFF);
      chk("rst_valid", 32'(bus0.valid), 32'h0);
      chk("rst_ovf",   32'(bus0.ovf), 32'h0);
      chk("rst_sout",  32'(bus0.sout), 32'h0);
      chk("rst_q_t",   bus1.q, 32'h0000_0000);

      // 2 load and handshake on ch0
      rst = 1'b0; mode = MODE_LOAD; en = 4'b0001; d = 32'h0000_00A5; ready = 4'h0;
      edge_step();
      chk("ld_q",     bus0.q, 32'h0000_00A5);
      chk("ld_qc",    bus0.qc, 32'hFFFF_FF5A);
      chk("ld_valid", 32'(bus0.valid), 32'h1);
      mode = MODE_HOLD; ready = 4'b0001;
      edge_step();
      chk("acc_valid", 32'(bus0.valid), 32'h0);
      chk("acc_q",     bus0.q, 32'h0000_00A5);
      ready = 4'h0;

      // 3 overflow on ch1, cleared only by clr
      mode = MODE_LOAD; en = 4'b0010; d = 32'h0000_1100;
      edge_step();
      chk("ov1_valid", 32'(bus0.valid), 32'h2);
      d = 32'h0000_2200;
      edge_step();
      chk("ov2_q",   bus0.q, 32'h0000_22A5);
      chk("ov2_ovf", 32'(bus0.ovf), 32'h2);
      d = 32'h0000_3300; ready = 4'b0010;
      edge_step();
      chk("ov3_q",     bus0.q, 32'h0000_33A5);
      chk("ov3_valid", 32'(bus0.valid), 32'h2);
      chk("ov3_ovf",   32'(bus0.ovf), 32'h2);
      mode = MODE_HOLD; ready = 4'h0; clr = 1'b1;
      edge_step();
      chk("clr_q",     bus0.q, 32'h0000_0000);
      chk("clr_valid", 32'(bus0.valid), 32'h0);
      chk("clr_ovf",   32'(bus0.ovf), 32'h0);
      clr = 1'b0;

      // 4 shifts on ch2
      mode = MODE_LOAD; en = 4'b0100; d = 32'h0081_0000;
      edge_step();
      mode = MODE_SHL; sin = 4'h0;
      #1;
      chk("shl_sout", 32'(bus0.sout), 32'h4);
      edge_step();
      chk("shl_q",     bus0.q, 32'h0002_0000);
      chk("shl_valid", 32'(bus0.valid), 32'h4);
      mode = MODE_LOAD;
      edge_step();
      mode = MODE_SHR; sin = 4'b0100;
      #1;
      chk("shr_sout", 32'(bus0.sout), 32'h4);
      edge_step();
      chk("shr_q", bus0.q, 32'h00C0_0000);
      mode = MODE_SHL; en = 4'h0; sin = 4'h0;
      #1;
      chk("shl_dis_sout", 32'(bus0.sout), 32'h4);
      edge_step();
      chk("shl_dis_q", bus0.q, 32'h00C0_0000);
      mode = MODE_HOLD;
      #1;
      chk("hold_sout", 32'(bus0.sout), 32'h0);

      // 5 transparency on ch3
      mode = MODE_LOAD; en = 4'b1000; d = 32'h1000_0000;
      #1;
      chk("tr_q10",  bus1.q, 32'h10C0_0000);
      chk("tr_qc10", bus1.qc, 32'hEF3F_FFFF);
      chk("reg_q10", bus0.q, 32'h00C0_0000);
      d = 32'h2000_0000;
      #1;
      chk("tr_q20", bus1.q, 32'h20C0_0000);
      edge_step();
      mode = MODE_HOLD; d = 32'h3000_0000;
      #1;
      chk("tr_hold_q",  bus1.q, 32'h20C0_0000);
      chk("reg_hold_q", bus0.q, 32'h20C0_0000);

      // 6 priority: rst over clr over load
      rst = 1'b1; clr = 1'b1; mode = MODE_LOAD; en = 4'hF; d = 32'hFFFF_FFFF; ready = 4'hF;
      #1;
      chk("pri_rst_tr_q", bus1.q, 32'h20C0_0000);
      edge_step();
      chk("pri_rst_q",     bus0.q, 32'h0000_0000);
      chk("pri_rst_valid", 32'(bus0.valid), 32'h0);
      chk("pri_rst_q_t",   bus1.q, 32'h0000_0000);
      rst = 1'b0; clr = 1'b0; en = 4'b0001; d = 32'h0000_005A; ready = 4'h0;
      edge_step();
      chk("pri_ld_valid", 32'(bus0.valid), 32'h1);
      clr = 1'b1; en = 4'hF; d = 32'hFFFF_FFFF; ready = 4'hF;
      #1;
      chk("pri_clr_tr_q", bus1.q, 32'h0000_005A);
      edge_step();
      chk("pri_clr_q",     bus0.q, 32'h0000_0000);
      chk("pri_clr_valid", 32'(bus0.valid), 32'h0);
      chk("pri_clr_ovf",   32'(bus0.ovf), 32'h0);
      clr = 1'b0; mode = MODE_HOLD;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
